// File: rtl/volume_bar_renderer.sv
// volume_bar_renderer: 2-stage OLED pixel shader for a 15-segment volume bar with peak hold and border.
module volume_bar_renderer #(
  parameter int BAR_X0           = 40,
  parameter int BAR_X1           = 55,
  parameter int PEAK_HOLD_FRAMES = 30,
  parameter int DECAY_FRAMES     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] pixel_index,
  input  logic        frame_begin,
  input  logic [3:0]  level,
  input  logic        level_valid,
  input  logic        border_en,
  input  logic [15:0] back_col,
  input  logic [15:0] low_col,
  input  logic [15:0] med_col,
  input  logic [15:0] high_col,
  input  logic [15:0] border_col,
  output logic [15:0] pixel_data
);
  localparam int HW = $clog2(PEAK_HOLD_FRAMES + 1);
  localparam int DW = $clog2(DECAY_FRAMES + 1);
  localparam logic [6:0] X0 = 7'(BAR_X0);
  localparam logic [6:0] X1 = 7'(BAR_X1);
  logic [3:0] pend_q, pend_d, act_q, act_d, peak_q, peak_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [DW-1:0] dec_q, dec_d;
  logic [15:0] back_q, low_q, med_q, high_q, bord_q;
  logic bord_en_q;
  logic [6:0] x_q, y_q, x_d, y_d;
  logic oob_q, oob_d;
  logic [15:0] pix_q, pix_d;
  logic [6:0] d;
  logic [4:0] s;
  logic seg, edge_px;
  logic [15:0] seg_col;
  assign y_d   = 7'(pixel_index / 13'd96);
  assign x_d   = 7'(pixel_index % 13'd96);
  assign oob_d = pixel_index >= 13'd6144;
  assign pend_d = level_valid ? level : pend_q;
  assign act_d  = frame_begin ? (level_valid ? level : pend_q) : act_q;
  // Peak tracks the freshly latched level so it can never sit below the drawn bar.
  always_comb begin
    peak_d = peak_q;
    hold_d = hold_q;
    dec_d  = dec_q;
    if (frame_begin) begin
      if (act_d >= peak_q) begin
        peak_d = act_d;
        hold_d = HW'(PEAK_HOLD_FRAMES);
        dec_d  = '0;
      end else if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else if (dec_q == DW'(DECAY_FRAMES - 1)) begin
        peak_d = (peak_q == 4'd0) ? 4'd0 : peak_q - 4'd1;
        dec_d  = '0;
      end else begin
        dec_d = dec_q + 1'b1;
      end
    end
  end
  // Each segment is 3 rows tall with a 1-row gap where d[1:0] == 3.
  assign d       = 7'd66 - y_q;
  assign s       = d[6:2];
  assign seg     = x_q >= X0 && x_q <= X1 && s >= 5'd1 && s <= 5'd15 && d[1:0] != 2'd3;
  assign seg_col = s <= 5'd5 ? low_q : s <= 5'd10 ? med_q : high_q;
  assign edge_px = bord_en_q && (x_q == 7'd0 || x_q == 7'd95 || y_q == 7'd0 || y_q == 7'd63);
  assign pix_d   = oob_q ? back_q :
                   edge_px ? bord_q :
                   (seg && (s <= {1'b0, act_q} || (s == {1'b0, peak_q} && peak_q != 4'd0))) ? seg_col :
                   back_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      act_q     <= '0;
      peak_q    <= '0;
      hold_q    <= '0;
      dec_q     <= '0;
      back_q    <= '0;
      low_q     <= '0;
      med_q     <= '0;
      high_q    <= '0;
      bord_q    <= '0;
      bord_en_q <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      oob_q     <= 1'b0;
      pix_q     <= '0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      peak_q <= peak_d;
      hold_q <= hold_d;
      dec_q  <= dec_d;
      if (frame_begin) begin
        back_q    <= back_col;
        low_q     <= low_col;
        med_q     <= med_col;
        high_q    <= high_col;
        bord_q    <= border_col;
        bord_en_q <= border_en;
      end
      x_q   <= x_d;
      y_q   <= y_d;
      oob_q <= oob_d;
      pix_q <= pix_d;
    end
  end
  assign pixel_data = pix_q;
endmodule

// File: tb/tb_volume_bar_renderer.sv
// tb_volume_bar_renderer: directed checks of volume_bar_renderer colour, peak hold/decay, border and reset.
module tb_volume_bar_renderer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [12:0] pixel_index = '0;
  logic        frame_begin = 1'b0;
  logic [3:0]  level = '0;
  logic        level_valid = 1'b0;
  logic        border_en = 1'b0;
  logic [15:0] back_col = '0, low_col = '0, med_col = '0, high_col = '0, border_col = '0;
  logic [15:0] pixel_data;
  int checks = 0;
  int errors = 0;
  localparam logic [15:0] A_BK = 16'h0001, A_LO = 16'h07E0, A_ME = 16'hFFE0, A_HI = 16'hF800, A_BD = 16'hFFFF;
  localparam logic [15:0] BK = 16'h001F, LO = 16'h0400, ME = 16'h8400, HI = 16'h8000, BD = 16'h4208;
  volume_bar_renderer dut (
    .clk(clk), .rst(rst), .pixel_index(pixel_index), .frame_begin(frame_begin),
    .level(level), .level_valid(level_valid), .border_en(border_en),
    .back_col(back_col), .low_col(low_col), .med_col(med_col), .high_col(high_col),
    .border_col(border_col), .pixel_data(pixel_data)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [15:0] exp);
    checks++;
    assert (pixel_data === exp) else begin
      errors++;
      $error("FAIL %s: pixel_data=%h expected %h", tag, pixel_data, exp);
    end
  endtask
  task automatic pix(input string tag, input int idx, input logic [15:0] exp);
    pixel_index = 13'(idx);
    step();
    step();
    check(tag, exp);
  endtask
  task automatic frame();
    frame_begin = 1'b1;
    step();
    frame_begin = 1'b0;
  endtask
  task automatic strobe(input logic [3:0] lv);
    level = lv;
    level_valid = 1'b1;
    step();
    level_valid = 1'b0;
  endtask
  task automatic set_cols(input logic [15:0] b, l, m, h, e);
    back_col = b; low_col = l; med_col = m; high_col = h; border_col = e;
  endtask
  initial begin
    step();
    step();
    rst = 1'b0;
    check("reset_out", 16'h0000);
    for (int i = 0; i < 6146; i++) begin
      pixel_index = (i < 6144) ? 13'(i) : 13'd0;
      step();
      check("sweep_zero", 16'h0000);
    end
    set_cols(A_BK, A_LO, A_ME, A_HI, A_BD);
    frame();
    pix("themeA_bg", 0, A_BK);
    set_cols(BK, LO, ME, HI, BD);
    pix("themeA_hold", 0, A_BK);
    pix("themeA_hold_seg", 5805, A_BK);
    frame();
    pix("themeB_bg", 0, BK);
    strobe(4'd7);
    frame();
    pix("l7_low", 5805, LO);
    pix("l7_med", 3501, ME);
    pix("l7_above", 3117, BK);
    pix("l7_gap", 3405, BK);
    pix("l7_left", 5799, BK);
    pixel_index = 13'd5805;
    step();
    step();
    pixel_index = 13'd3117;
    step();
    check("lag1", LO);
    step();
    check("lag2", BK);
    strobe(4'd12);
    frame();
    pix("l12_high", 1581, HI);
    for (int f = 1; f <= 78; f++) begin
      strobe(4'd0);
      frame();
      if (f == 1) pix("drop1_seg1", 5805, BK);
      if (f == 1) pix("drop1_peak", 1581, HI);
      if (f == 30) pix("drop30_peak", 1581, HI);
      if (f == 33) pix("drop33_peak", 1581, HI);
      if (f == 34) pix("drop34_old", 1581, BK);
      if (f == 34) pix("drop34_new", 1965, HI);
      if (f == 77) pix("drop77_peak1", 5805, LO);
      if (f == 78) pix("drop78_peak0", 5805, BK);
    end
    border_en = 1'b1;
    frame();
    pix("bd_0", 0, BD);
    pix("bd_95", 95, BD);
    pix("bd_6048", 6048, BD);
    pix("bd_6143", 6143, BD);
    pix("bd_oob", 6200, BK);
    border_en = 1'b0;
    frame();
    pix("nobd_0", 0, BK);
    pix("nobd_6143", 6143, BK);
    level = 4'd15;
    level_valid = 1'b1;
    frame_begin = 1'b1;
    step();
    level_valid = 1'b0;
    frame_begin = 1'b0;
    pix("bypass_top", 429, HI);
    pix("bypass_low", 5805, LO);
    pixel_index = 13'd429;
    step();
    rst = 1'b1;
    step();
    check("rst_mid", 16'h0000);
    rst = 1'b0;
    pix("rst_shadow", 429, 16'h0000);
    frame();
    pix("rst_lvl_top", 429, BK);
    pix("rst_lvl_low", 5805, BK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
